trail_stack: RTL and testbench
==============================

# trail_stack

Parametrised assignment trail for the DPLL solver core. It records decided and implied literals in push order and supports single pops and a hardware chronological backtrack. Backtrack unwinds forced entries down to the most recent decision, streaming every popped literal out for unassignment. It replaces the fixed-size decide/imply stack and sits between the decision unit, the BCP engine and the variable-state table.

## Interface
- DEPTH, default `MAX_VARS: entry capacity.
- VAR_W, default `MAX_VARS_BITS: variable index width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- push  in  1  push request.
- push_type  in  1  0 = decision, 1 = forced.
- push_val  in  1  literal value.
- push_var  in  VAR_W  variable index.
- pop  in  1  single-entry pop request.
- bt_start  in  1  start a backtrack.
- out_valid  out  1  popped entry present on out_* this cycle.
- out_type, out_val  out  1 each  popped entry fields.
- out_var  out  VAR_W  popped entry variable.
- top_type, top_val  out  1 each  current top entry; 0 when empty.
- top_var  out  VAR_W  current top entry variable; 0 when empty.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- dlevel  out  $clog2(DEPTH)+1  number of decision entries on the stack.
- empty, full  out  1 each  count==0 / count==DEPTH.
- overflow  out  1  sticky; set by a push dropped while full.
- bt_busy  out  1  backtrack in progress.
- bt_done  out  1  one-cycle pulse at the end of a backtrack.
- bt_fail  out  1  pulse with bt_done when no decision was found.

## Operation
- FSM states: IDLE, BT_POP, BT_FLIP (BT_FLIP exists only with the macro).
- Reset values:
  - count=0, dlevel=0, empty=1, full=0, overflow=0, state IDLE.
  - All out_*, top_*, bt_* signals are 0.
  - Storage array is not reset.
- IDLE command priority: bt_start > (pop, push).
- pop alone, non-empty: remove top; the entry appears on out_* with out_valid the next cycle.
- pop while empty: ignored; no out_valid.
- push alone, not full: write entry at count; count+1.
- push while full: entry dropped; overflow set.
- push and pop in the same cycle, non-empty: top is popped and emitted, then replaced by the pushed entry; count unchanged.
- push and pop in the same cycle, empty: treated as push only.
- dlevel: +1 on every stored decision push, −1 on every decision pop; a replace applies both adjustments.
- bt_start, non-empty: enter BT_POP.
  - Each cycle in BT_POP pops one entry and emits it.
  - Popping a forced entry stays in BT_POP.
  - Popping a decision entry leaves BT_POP.
  - If the stack empties without popping a decision: bt_done and bt_fail pulse, stack empty, return to IDLE.
- bt_start while empty: bt_done and bt_fail pulse the next cycle; no out_valid.
- push, pop and bt_start are ignored while bt_busy is high.
- reset mid-backtrack: abort to IDLE; no bt_done.

## Timing
- Cycle 0: bt_start sampled. The first pop happens at the edge ending cycle 0.
- With k forced entries above the nearest decision:
  - out_valid is high in cycles 1..k+1; top entry first, decision entry last.
  - bt_busy is high in cycles 1..(bt_done cycle − 1).
- top_*, count, dlevel, empty and full are registered and reflect the state after the previous edge.
- Single pop latency: 1 cycle to out_valid.
- Throughput: one push or pop per cycle.
- New commands are accepted in the bt_done cycle.

## Configuration
- TRAIL_BT_FLIP_EN defined:
  - After the decision is popped, the FSM spends one BT_FLIP cycle pushing {forced, ~val, var}.
  - bt_done pulses in cycle k+2.
  - Net count after backtrack = count − k; dlevel − 1.
- TRAIL_BT_FLIP_EN undefined:
  - No re-push; BT_FLIP does not exist.
  - bt_done pulses in cycle k+1, coincident with the last out_valid.
  - Net count = count − k − 1.

## Test plan
- Reset, then pop -> no out_valid; empty=1, count=0, top_*=0.
- Push (D,1,3),(F,0,5),(F,1,7), then bt_start -> out_valid cycles 1–3 with vars 7,5,3.
  - With flip: bt_done in cycle 4, top=(F,0,3), count=1, dlevel=0.
  - Without flip: bt_done in cycle 3, empty=1.
- Push (F,1,2),(F,0,4), then bt_start -> vars 4,2 emitted; bt_done and bt_fail pulse together in cycle 2; empty=1.
- DEPTH=4: five pushes -> full=1, count=4, overflow=1; 5th entry absent after four pops.
- Push A; in one cycle push B and pop -> out=A next cycle; top=B; count=1.
- Push 3 forced + 1 decision; bt_start; assert reset in cycle 1 -> count=0, empty=1, bt_busy=0, no bt_done.

Source files
------------

// File: rtl/trail_stack_if.sv
// Handshake bundle between the trail stack and its clients (decision unit, BCP, var table).
// Default sizes come from MAX_VARS / MAX_VARS_BITS when the core does not provide them.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

interface trail_stack_if #(
    parameter int unsigned DEPTH = `MAX_VARS,
    parameter int unsigned VAR_W = `MAX_VARS_BITS
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             push_type;
    logic             push_val;
    logic [VAR_W-1:0] push_var;
    logic             pop;
    logic             bt_start;

    logic             out_valid;
    logic             out_type;
    logic             out_val;
    logic [VAR_W-1:0] out_var;
    logic             top_type;
    logic             top_val;
    logic [VAR_W-1:0] top_var;
    logic [CW-1:0]    count;
    logic [CW-1:0]    dlevel;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             bt_busy;
    logic             bt_done;
    logic             bt_fail;

    modport master (
        output push, push_type, push_val, push_var, pop, bt_start,
        input  out_valid, out_type, out_val, out_var, top_type, top_val, top_var,
        input  count, dlevel, empty, full, overflow, bt_busy, bt_done, bt_fail
    );

    modport slave (
        input  push, push_type, push_val, push_var, pop, bt_start,
        output out_valid, out_type, out_val, out_var, top_type, top_val, top_var,
        output count, dlevel, empty, full, overflow, bt_busy, bt_done, bt_fail
    );
endinterface

// File: rtl/trail_stack.sv
// Assignment trail with single pop, push/pop replace and chronological backtrack.
// Define TRAIL_BT_FLIP_EN to re-push the flipped decision as a forced entry after backtrack.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module trail_stack #(
    parameter int unsigned DEPTH = `MAX_VARS,
    parameter int unsigned VAR_W = `MAX_VARS_BITS
) (
    input logic          clock,
    input logic          reset,
    trail_stack_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             typ;   // 0 = decision, 1 = forced
        logic             val;
        logic [VAR_W-1:0] vidx;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StBtPop
`ifdef TRAIL_BT_FLIP_EN
        ,
        StBtFlip
`endif
    } state_e;

    state_e        state_q, state_d;
    entry_t        mem_q [DEPTH];
    entry_t        top_q, top_d;
    entry_t        out_q, out_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] dlevel_q, dlevel_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          out_valid_q, out_valid_d;
    logic          bt_busy_q, bt_busy_d;
    logic          bt_done_q, bt_done_d;
    logic          bt_fail_q, bt_fail_d;
`ifdef TRAIL_BT_FLIP_EN
    entry_t        flip_q, flip_d;
`endif

    logic          we;
    logic [AW-1:0] waddr;
    entry_t        wdata;
    logic          bt_step;
    entry_t        push_e;
    entry_t        below_e;
    logic [AW-1:0] idx_top;
    logic [AW-1:0] idx_below;
    logic [AW-1:0] idx_free;

    assign push_e    = '{typ: bus.push_type, val: bus.push_val, vidx: bus.push_var};
    assign idx_top   = AW'(count_q - CW'(1));
    assign idx_below = AW'(count_q - CW'(2));
    assign idx_free  = AW'(count_q);
    // Entry that becomes the top after a plain pop.
    assign below_e   = (count_q >= CW'(2)) ? mem_q[idx_below] : '0;

    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        out_d       = out_q;
        count_d     = count_q;
        dlevel_d    = dlevel_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        bt_busy_d   = bt_busy_q;
        bt_done_d   = 1'b0;
        bt_fail_d   = 1'b0;
`ifdef TRAIL_BT_FLIP_EN
        flip_d      = flip_q;
`endif
        we          = 1'b0;
        waddr       = idx_free;
        wdata       = push_e;
        bt_step     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.bt_start) begin
                    if (empty_q) begin
                        bt_done_d = 1'b1;
                        bt_fail_d = 1'b1;
                    end else begin
                        bt_step = 1'b1;
                    end
                end else if (bus.pop && !empty_q) begin
                    out_valid_d = 1'b1;
                    out_d       = top_q;
                    if (bus.push) begin
                        // Replace: emit old top, overwrite its slot, depth unchanged.
                        we       = 1'b1;
                        waddr    = idx_top;
                        top_d    = push_e;
                        dlevel_d = dlevel_q - CW'(!top_q.typ) + CW'(!bus.push_type);
                    end else begin
                        count_d  = count_q - CW'(1);
                        dlevel_d = dlevel_q - CW'(!top_q.typ);
                        top_d    = below_e;
                    end
                end else if (bus.push) begin
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        we       = 1'b1;
                        waddr    = idx_free;
                        top_d    = push_e;
                        count_d  = count_q + CW'(1);
                        dlevel_d = dlevel_q + CW'(!bus.push_type);
                    end
                end
            end
            StBtPop: begin
                bt_step = 1'b1;
            end
`ifdef TRAIL_BT_FLIP_EN
            StBtFlip: begin
                we        = 1'b1;
                waddr     = idx_free;
                wdata     = flip_q;
                top_d     = flip_q;
                count_d   = count_q + CW'(1);
                bt_done_d = 1'b1;
                bt_busy_d = 1'b0;
                state_d   = StIdle;
            end
`endif
            default: begin
                state_d   = StIdle;
                bt_busy_d = 1'b0;
            end
        endcase

        // One backtrack pop; the popped entry's type decides whether to continue.
        if (bt_step) begin
            out_valid_d = 1'b1;
            out_d       = top_q;
            count_d     = count_q - CW'(1);
            top_d       = below_e;
            if (!top_q.typ) begin
                dlevel_d = dlevel_q - CW'(1);
`ifdef TRAIL_BT_FLIP_EN
                flip_d    = '{typ: 1'b1, val: ~top_q.val, vidx: top_q.vidx};
                state_d   = StBtFlip;
                bt_busy_d = 1'b1;
`else
                state_d   = StIdle;
                bt_busy_d = 1'b0;
                bt_done_d = 1'b1;
`endif
            end else if (count_q == CW'(1)) begin
                state_d   = StIdle;
                bt_busy_d = 1'b0;
                bt_done_d = 1'b1;
                bt_fail_d = 1'b1;
            end else begin
                state_d   = StBtPop;
                bt_busy_d = 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            top_q       <= '0;
            out_q       <= '0;
            count_q     <= '0;
            dlevel_q    <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bt_busy_q   <= 1'b0;
            bt_done_q   <= 1'b0;
            bt_fail_q   <= 1'b0;
`ifdef TRAIL_BT_FLIP_EN
            flip_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            out_q       <= out_d;
            count_q     <= count_d;
            dlevel_q    <= dlevel_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            bt_busy_q   <= bt_busy_d;
            bt_done_q   <= bt_done_d;
            bt_fail_q   <= bt_fail_d;
`ifdef TRAIL_BT_FLIP_EN
            flip_q      <= flip_d;
`endif
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_type  = out_q.typ;
    assign bus.out_val   = out_q.val;
    assign bus.out_var   = out_q.vidx;
    assign bus.top_type  = top_q.typ;
    assign bus.top_val   = top_q.val;
    assign bus.top_var   = top_q.vidx;
    assign bus.count     = count_q;
    assign bus.dlevel    = dlevel_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = overflow_q;
    assign bus.bt_busy   = bt_busy_q;
    assign bus.bt_done   = bt_done_q;
    assign bus.bt_fail   = bt_fail_q;
endmodule

// File: tb/tb_trail_stack.sv
// Directed plus randomized bench for trail_stack against a queue-based trail model.
module tb_trail_stack;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned VAR_W = 4;
`ifdef TRAIL_BT_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    typedef struct packed {
        logic             typ;
        logic             val;
        logic [VAR_W-1:0] vidx;
    } ent_t;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_mis;
    ent_t stk[$];
    bit   ovf;

    trail_stack_if #(.DEPTH(DEPTH), .VAR_W(VAR_W)) bus ();

    trail_stack #(.DEPTH(DEPTH), .VAR_W(VAR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.push      = 1'b0;
        bus.push_type = 1'b0;
        bus.push_val  = 1'b0;
        bus.push_var  = '0;
        bus.pop       = 1'b0;
        bus.bt_start  = 1'b0;
    endtask

    task automatic chk_state(input string where);
        int   dl;
        ent_t t;
        dl = 0;
        foreach (stk[i]) if (!stk[i].typ) dl++;
        t = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        chk({where, " count"}, 32'(bus.count), 32'(stk.size()));
        chk({where, " dlevel"}, 32'(bus.dlevel), 32'(dl));
        chk({where, " empty"}, 32'(bus.empty), 32'(stk.size() == 0));
        chk({where, " full"}, 32'(bus.full), 32'(stk.size() == DEPTH));
        chk({where, " overflow"}, 32'(bus.overflow), 32'(ovf));
        chk({where, " top"}, 32'({bus.top_type, bus.top_val, bus.top_var}), 32'(t));
    endtask

    // One IDLE-state command: push and/or pop.
    task automatic do_op(input bit p, input bit t, input bit v, input logic [VAR_W-1:0] x,
                         input bit q);
        bit   ev;
        ent_t eo;
        ent_t ne;
        ev = 1'b0;
        eo = '0;
        ne = '{typ: t, val: v, vidx: x};
        if (q && stk.size() > 0) begin
            ev = 1'b1;
            eo = stk.pop_back();
            if (p) stk.push_back(ne);
        end else if (p) begin
            if (stk.size() == DEPTH) ovf = 1'b1;
            else stk.push_back(ne);
        end
        bus.push      = p;
        bus.push_type = t;
        bus.push_val  = v;
        bus.push_var  = x;
        bus.pop       = q;
        @(posedge clock);
        #1;
        idle_inputs();
        chk("op out_valid", 32'(bus.out_valid), 32'(ev));
        if (ev) chk("op out_entry", 32'({bus.out_type, bus.out_val, bus.out_var}), 32'(eo));
        chk("op bt_done", 32'(bus.bt_done), 32'(0));
        chk("op bt_busy", 32'(bus.bt_busy), 32'(0));
        chk_state("op");
    endtask

    // Full backtrack; commands driven while busy must be ignored.
    task automatic do_bt();
        ent_t pl[$];
        ent_t e;
        bit   found;
        int   n;
        int   done;
        found = 1'b0;
        e = '0;
        while (stk.size() > 0 && !found) begin
            e = stk.pop_back();
            pl.push_back(e);
            if (!e.typ) found = 1'b1;
        end
        n = pl.size();
        if (found && FLIP) begin
            done = n + 1;
            stk.push_back('{typ: 1'b1, val: ~e.val, vidx: e.vidx});
        end else begin
            done = (n == 0) ? 1 : n;
        end
        bus.bt_start  = 1'b1;
        bus.push      = 1'($urandom_range(0, 1));
        bus.pop       = 1'($urandom_range(0, 1));
        bus.push_var  = VAR_W'($urandom_range(0, 15));
        @(posedge clock);
        #1;
        for (int c = 1; c <= done; c++) begin
            chk("bt out_valid", 32'(bus.out_valid), 32'(c <= n));
            if (c <= n)
                chk("bt out_entry", 32'({bus.out_type, bus.out_val, bus.out_var}), 32'(pl[c-1]));
            chk("bt busy", 32'(bus.bt_busy), 32'(c < done));
            chk("bt done", 32'(bus.bt_done), 32'(c == done));
            chk("bt fail", 32'(bus.bt_fail), 32'((c == done) && !found));
            if (c == done) begin
                idle_inputs();
                chk_state("bt end");
            end else begin
                bus.bt_start  = 1'($urandom_range(0, 1));
                bus.push      = 1'($urandom_range(0, 1));
                bus.pop       = 1'($urandom_range(0, 1));
                bus.push_type = 1'($urandom_range(0, 1));
                bus.push_var  = VAR_W'($urandom_range(0, 15));
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        ovf   = 1'b0;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_state("reset");
        chk("reset out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset out_entry", 32'({bus.out_type, bus.out_val, bus.out_var}), 32'(0));
        chk("reset busy", 32'(bus.bt_busy), 32'(0));
        chk("reset done", 32'(bus.bt_done), 32'(0));
        chk("reset fail", 32'(bus.bt_fail), 32'(0));

        do_op(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Decision below two forced entries.
        do_op(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
        do_op(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
        do_bt();
        while (stk.size() > 0) do_op(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // No decision on the stack.
        do_op(1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
        do_bt();
        do_bt();

        // Overflow: the fifth entry must be dropped.
        for (int i = 0; i < 5; i++)
            do_op(1'b1, 1'(i % 2), 1'(i / 2), VAR_W'(i + 9), 1'b0);
        for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Replace.
        do_op(1'b1, 1'b0, 1'b1, 4'd6, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 4'd11, 1'b1);
        do_op(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Reset in cycle 1 of a backtrack.
        do_op(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
        do_op(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
        bus.bt_start = 1'b1;
        @(posedge clock);
        #1;
        idle_inputs();
        chk("abort busy", 32'(bus.bt_busy), 32'(1));
        chk("abort first out", 32'({bus.out_valid, bus.out_var}), 32'({1'b1, 4'd4}));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        stk.delete();
        ovf = 1'b0;
        chk_state("abort");
        chk("abort busy after", 32'(bus.bt_busy), 32'(0));
        chk("abort done", 32'(bus.bt_done), 32'(0));
        chk("abort out_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clock);
        #1;
        chk("abort done later", 32'(bus.bt_done), 32'(0));

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) do_bt();
            else if (r <= 2) do_op(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            else if (r == 3)
                do_op(1'b1, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                      VAR_W'($urandom_range(0, 15)), 1'b1);
            else
                do_op(1'b1, 1'($urandom_range(0, 4) > 1), 1'($urandom_range(0, 1)),
                      VAR_W'($urandom_range(0, 15)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
